// File: rtl/detector_nota_tempo.sv
// rtl/detector_nota_tempo.sv - piano key debounce, note lock, tick-duration measure and result compare
//
// Purpose: debounces the raw key lines, locks onto the lowest pressed key,
// counts metronome ticks while it is held and, once the release is debounced,
// compares note and duration against the values supplied by song memory.
//
// Optional feature macro: DETECTOR_MULTITECLA_ERRO_EN (sticky extra-key flag
// that forces nota_correta to 0 at evaluation).
//
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   botoes              raw key lines, active high
//   tick_metro          one-cycle metronome subdivision pulse
//   nota_esperada       expected note code (0 = rest)
//   duracao_esperada    expected hold length in ticks
//   limpa               clears the latched comparison flags
//   nota_feita          high while a debounced key is held
//   nota_tocada         locked key code, 0 when none
//   duracao_medida      ticks counted during the current or last press
//   resultado_valido    one-cycle pulse when a comparison completes
//   nota_correta        latched note comparison
//   tempo_correto       latched duration comparison
//   db_estado           current FSM state
module detector_nota_tempo #(
    parameter int NUM_TECLAS = 12,
    parameter int DEB_CICLOS = 8,
    parameter int DUR_W      = 6,
    parameter int TOL        = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_TECLAS-1:0] botoes,
    input  logic                  tick_metro,
    input  logic [3:0]            nota_esperada,
    input  logic [DUR_W-1:0]      duracao_esperada,
    input  logic                  limpa,
    output logic                  nota_feita,
    output logic [3:0]            nota_tocada,
    output logic [DUR_W-1:0]      duracao_medida,
    output logic                  resultado_valido,
    output logic                  nota_correta,
    output logic                  tempo_correto,
    output logic [2:0]            db_estado
);

    localparam int CW = (DEB_CICLOS < 2) ? 1 : $clog2(DEB_CICLOS);

    typedef enum logic [2:0] {
        OCIOSO       = 3'd0,
        FILTRA_PRESS = 3'd1,
        PRESSIONADA  = 3'd2,
        FILTRA_SOLTA = 3'd3,
        AVALIA       = 3'd4
    } estado_t;

    estado_t          estado_q;
    logic [CW-1:0]    deb_q;
    logic [3:0]       cand_q;
    logic [3:0]       nota_tocada_q;
    logic [DUR_W-1:0] dur_q;
    logic             nota_feita_q;
    logic             valido_q;
    logic             nota_ok_q;
    logic             tempo_ok_q;

    // Lowest asserted index wins; code is index+1, 0 when no key is high.
    function automatic logic [3:0] codigo_menor(input logic [NUM_TECLAS-1:0] b);
        logic [3:0] r;
        r = 4'd0;
        for (int i = NUM_TECLAS - 1; i >= 0; i--) begin
            if (b[i]) r = 4'(i + 1);
        end
        return r;
    endfunction

    function automatic logic tecla_ativa(input logic [NUM_TECLAS-1:0] b, input logic [3:0] c);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_TECLAS; i++) begin
            if (c == 4'(i + 1)) r = b[i];
        end
        return r;
    endfunction

    logic [3:0]       cand_d;
    logic             tecla_cand;
    logic             tecla_trav;
    logic             deb_fim;
    logic [DUR_W-1:0] dur_d;
    logic [DUR_W:0]   med_x;
    logic [DUR_W:0]   esp_x;
    logic [DUR_W:0]   dif_x;
    logic             tempo_ok_d;
    logic             nota_ok_d;

    assign cand_d     = codigo_menor(botoes);
    assign tecla_cand = tecla_ativa(botoes, cand_q);
    assign tecla_trav = tecla_ativa(botoes, nota_tocada_q);
    assign deb_fim    = (deb_q == CW'(DEB_CICLOS - 1));
    // Saturating tick count: sticks at all-ones instead of wrapping.
    assign dur_d      = (dur_q == {DUR_W{1'b1}}) ? dur_q : dur_q + 1'b1;

    // Absolute difference in one extra bit so it never wraps.
    assign med_x      = {1'b0, dur_q};
    assign esp_x      = {1'b0, duracao_esperada};
    assign dif_x      = (med_x >= esp_x) ? (med_x - esp_x) : (esp_x - med_x);
    assign tempo_ok_d = (dif_x <= (DUR_W + 1)'(TOL));

`ifdef DETECTOR_MULTITECLA_ERRO_EN
    function automatic logic [NUM_TECLAS-1:0] mascara(input logic [3:0] c);
        logic [NUM_TECLAS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_TECLAS; i++) begin
            if (c == 4'(i + 1)) r[i] = 1'b1;
        end
        return r;
    endfunction

    logic [CW-1:0] mt_cnt_q;
    logic          multi_q;
    logic          outras;
    logic          mt_fim;

    assign outras    = |(botoes & ~mascara(nota_tocada_q));
    assign mt_fim    = (mt_cnt_q == CW'(DEB_CICLOS - 1));
    assign nota_ok_d = (nota_tocada_q == nota_esperada) && !multi_q;
`else
    assign nota_ok_d = (nota_tocada_q == nota_esperada);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q      <= OCIOSO;
            deb_q         <= '0;
            cand_q        <= 4'd0;
            nota_tocada_q <= 4'd0;
            dur_q         <= '0;
            nota_feita_q  <= 1'b0;
            valido_q      <= 1'b0;
            nota_ok_q     <= 1'b0;
            tempo_ok_q    <= 1'b0;
`ifdef DETECTOR_MULTITECLA_ERRO_EN
            mt_cnt_q      <= '0;
            multi_q       <= 1'b0;
`endif
        end else begin
            valido_q <= 1'b0;
            // AVALIA below overrides this when both happen together.
            if (limpa) begin
                nota_ok_q  <= 1'b0;
                tempo_ok_q <= 1'b0;
            end
            case (estado_q)
                OCIOSO: begin
                    if (|botoes) begin
                        cand_q   <= cand_d;
                        deb_q    <= '0;
                        estado_q <= FILTRA_PRESS;
                    end
                end
                FILTRA_PRESS: begin
                    if (!tecla_cand) begin
                        estado_q <= OCIOSO;
                    end else if (deb_fim) begin
                        nota_tocada_q <= cand_q;
                        dur_q         <= '0;
                        nota_feita_q  <= 1'b1;
                        estado_q      <= PRESSIONADA;
                    end else begin
                        deb_q <= deb_q + 1'b1;
                    end
                end
                PRESSIONADA: begin
                    if (tick_metro) dur_q <= dur_d;
                    if (!tecla_trav) begin
                        deb_q    <= '0;
                        estado_q <= FILTRA_SOLTA;
                    end
                end
                FILTRA_SOLTA: begin
                    if (tick_metro) dur_q <= dur_d;
                    if (tecla_trav) begin
                        estado_q <= PRESSIONADA;
                    end else if (deb_fim) begin
                        nota_feita_q <= 1'b0;
                        estado_q     <= AVALIA;
                    end else begin
                        deb_q <= deb_q + 1'b1;
                    end
                end
                AVALIA: begin
                    nota_ok_q     <= nota_ok_d;
                    tempo_ok_q    <= tempo_ok_d;
                    valido_q      <= 1'b1;
                    nota_tocada_q <= 4'd0;
                    estado_q      <= OCIOSO;
                end
                default: estado_q <= OCIOSO;
            endcase
`ifdef DETECTOR_MULTITECLA_ERRO_EN
            // Any non-locked key held long enough during the hold marks the press as dirty.
            if (estado_q == PRESSIONADA || estado_q == FILTRA_SOLTA) begin
                if (outras) begin
                    if (mt_fim) multi_q <= 1'b1;
                    else        mt_cnt_q <= mt_cnt_q + 1'b1;
                end else begin
                    mt_cnt_q <= '0;
                end
            end else if (estado_q == AVALIA) begin
                multi_q  <= 1'b0;
                mt_cnt_q <= '0;
            end
`endif
        end
    end

    assign nota_feita       = nota_feita_q;
    assign nota_tocada      = nota_tocada_q;
    assign duracao_medida   = dur_q;
    assign resultado_valido = valido_q;
    assign nota_correta     = nota_ok_q;
    assign tempo_correto    = tempo_ok_q;
    assign db_estado        = estado_q;

endmodule
